// File: rtl/scene_reader_pipelined.sv
// Scene reader: buffers instances in a small context FIFO, issues one model-buffer
// read per triangle, and pairs each returned triangle with its instance transform.
module scene_reader_pipelined #(
  parameter int MODEL_ID_W      = 8,
  parameter int TRI_IDX_W       = 16,
  parameter int TRANSFORM_W     = 384,
  parameter int TRIANGLE_W      = 288,
  parameter int CTX_DEPTH       = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   scene_in_valid,
  output logic                   scene_in_ready,
  input  logic [MODEL_ID_W-1:0]  scene_in_model_id,
  input  logic [TRI_IDX_W-1:0]   scene_in_tri_count,
  input  logic [TRANSFORM_W-1:0] scene_in_transform,
  input  logic                   scene_in_model_last,
  output logic                   model_out_valid,
  input  logic                   model_out_ready,
  output logic [MODEL_ID_W-1:0]  model_out_model_index,
  output logic [TRI_IDX_W-1:0]   model_out_triangle_index,
  input  logic                   model_in_valid,
  output logic                   model_in_ready,
  input  logic [TRIANGLE_W-1:0]  model_in_triangle,
  input  logic                   model_in_last,
  output logic                   tri_out_valid,
  input  logic                   tri_out_ready,
  output logic [TRANSFORM_W-1:0] tri_out_transform,
  output logic [TRIANGLE_W-1:0]  tri_out_triangle,
  output logic                   tri_out_triangle_last,
  output logic                   tri_out_model_last,
  output logic                   busy,
  output logic                   err_last_mismatch,
  output logic                   err_stray
);

  localparam int PTR_W = (CTX_DEPTH > 1) ? $clog2(CTX_DEPTH) : 1;
  localparam int OCC_W = PTR_W + 1;
  localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {ISSUE_IDLE, ISSUE_RUN} issue_state_t;

  logic [MODEL_ID_W-1:0]  ctx_id    [CTX_DEPTH];
  logic [TRI_IDX_W-1:0]   ctx_count [CTX_DEPTH];
  logic [TRANSFORM_W-1:0] ctx_tr    [CTX_DEPTH];
  logic                   ctx_ml    [CTX_DEPTH];

  issue_state_t         state, state_nxt;
  logic [PTR_W-1:0]     wr_ptr, rd_ptr, iss_ptr;
  logic [OCC_W-1:0]     occ, pend;
  logic [OUT_W-1:0]     outst;
  logic [TRI_IDX_W-1:0] iss_idx, resp_idx;

  logic ctx_full, scene_fire, wr_en;
  logic iss_last, req_fire, iss_done;
  logic has_out, out_fire, retire, stray;

  // Scene accept: zero-triangle instances are consumed without occupying a slot.
  assign ctx_full       = (occ == OCC_W'(CTX_DEPTH));
  assign scene_in_ready = !rst && !ctx_full;
  assign scene_fire     = scene_in_valid && scene_in_ready;
  assign wr_en          = scene_fire && (scene_in_tri_count != '0);

  // Issue side: the request stays stable while valid && !ready because only req_fire advances it.
  assign model_out_valid          = (state == ISSUE_RUN) && (outst < OUT_W'(MAX_OUTSTANDING));
  assign model_out_model_index    = ctx_id[iss_ptr];
  assign model_out_triangle_index = iss_idx;
  assign iss_last                 = (iss_idx == ctx_count[iss_ptr] - TRI_IDX_W'(1));
  assign req_fire                 = model_out_valid && model_out_ready;
  assign iss_done                 = req_fire && iss_last;

  // Response side: combinational pass-through; responses with no credit are swallowed.
  assign has_out               = (outst != '0);
  assign tri_out_valid         = model_in_valid && has_out;
  assign model_in_ready        = tri_out_ready || !has_out;
  assign tri_out_transform     = ctx_tr[rd_ptr];
  assign tri_out_model_last    = ctx_ml[rd_ptr];
  assign tri_out_triangle      = model_in_triangle;
  assign tri_out_triangle_last = (resp_idx == ctx_count[rd_ptr] - TRI_IDX_W'(1));
  assign out_fire              = tri_out_valid && tri_out_ready;
  assign retire                = out_fire && tri_out_triangle_last;
  assign stray                 = model_in_valid && !has_out;

  assign busy = (occ != '0) || has_out;

  // A write in the same cycle keeps the issuer running so the new context needs no idle bubble.
  always_comb begin
    state_nxt = state;
    case (state)
      ISSUE_IDLE: if ((pend != '0) || wr_en) state_nxt = ISSUE_RUN;
      ISSUE_RUN:  if (iss_done && !((pend > OCC_W'(1)) || wr_en)) state_nxt = ISSUE_IDLE;
      default:    state_nxt = ISSUE_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= ISSUE_IDLE;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      iss_ptr           <= '0;
      occ               <= '0;
      pend              <= '0;
      outst             <= '0;
      iss_idx           <= '0;
      resp_idx          <= '0;
      err_last_mismatch <= 1'b0;
      err_stray         <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      case ({wr_en, retire})
        2'b10:   occ <= occ + OCC_W'(1);
        2'b01:   occ <= occ - OCC_W'(1);
        default: occ <= occ;
      endcase
      case ({wr_en, iss_done})
        2'b10:   pend <= pend + OCC_W'(1);
        2'b01:   pend <= pend - OCC_W'(1);
        default: pend <= pend;
      endcase
      if (req_fire) iss_idx <= iss_last ? '0 : iss_idx + TRI_IDX_W'(1);
      if (iss_done) iss_ptr <= iss_ptr + PTR_W'(1);
      case ({req_fire, out_fire})
        2'b10:   outst <= outst + OUT_W'(1);
        2'b01:   outst <= outst - OUT_W'(1);
        default: outst <= outst;
      endcase
      if (out_fire) resp_idx <= tri_out_triangle_last ? '0 : resp_idx + TRI_IDX_W'(1);
      if (retire) rd_ptr <= rd_ptr + PTR_W'(1);
      if (out_fire && (model_in_last != tri_out_triangle_last)) err_last_mismatch <= 1'b1;
      if (stray) err_stray <= 1'b1;
    end
  end

  // Context storage carries data only and is never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ctx_id[wr_ptr]    <= scene_in_model_id;
      ctx_count[wr_ptr] <= scene_in_tri_count;
      ctx_tr[wr_ptr]    <= scene_in_transform;
      ctx_ml[wr_ptr]    <= scene_in_model_last;
    end
  end

endmodule

// File: tb/tb_scene_reader_pipelined.sv
// Directed bench for scene_reader_pipelined: a per-cycle vector table for the
// single-instance case plus hand-written multi-cycle sequences.
module tb_scene_reader_pipelined;

  localparam int MODEL_ID_W = 8, TRI_IDX_W = 16, TRANSFORM_W = 384, TRIANGLE_W = 288;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic                   scene_in_valid, scene_in_ready, scene_in_model_last;
  logic [MODEL_ID_W-1:0]  scene_in_model_id;
  logic [TRI_IDX_W-1:0]   scene_in_tri_count;
  logic [TRANSFORM_W-1:0] scene_in_transform;
  logic                   model_out_valid, model_out_ready;
  logic [MODEL_ID_W-1:0]  model_out_model_index;
  logic [TRI_IDX_W-1:0]   model_out_triangle_index;
  logic                   model_in_valid, model_in_ready, model_in_last;
  logic [TRIANGLE_W-1:0]  model_in_triangle;
  logic                   tri_out_valid, tri_out_ready, tri_out_triangle_last, tri_out_model_last;
  logic [TRANSFORM_W-1:0] tri_out_transform;
  logic [TRIANGLE_W-1:0]  tri_out_triangle;
  logic                   busy, err_last_mismatch, err_stray;

  scene_reader_pipelined dut (
    .clk(clk), .rst(rst),
    .scene_in_valid(scene_in_valid), .scene_in_ready(scene_in_ready),
    .scene_in_model_id(scene_in_model_id), .scene_in_tri_count(scene_in_tri_count),
    .scene_in_transform(scene_in_transform), .scene_in_model_last(scene_in_model_last),
    .model_out_valid(model_out_valid), .model_out_ready(model_out_ready),
    .model_out_model_index(model_out_model_index), .model_out_triangle_index(model_out_triangle_index),
    .model_in_valid(model_in_valid), .model_in_ready(model_in_ready),
    .model_in_triangle(model_in_triangle), .model_in_last(model_in_last),
    .tri_out_valid(tri_out_valid), .tri_out_ready(tri_out_ready),
    .tri_out_transform(tri_out_transform), .tri_out_triangle(tri_out_triangle),
    .tri_out_triangle_last(tri_out_triangle_last), .tri_out_model_last(tri_out_model_last),
    .busy(busy), .err_last_mismatch(err_last_mismatch), .err_stray(err_stray)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct { logic [7:0] id; logic [15:0] idx; int cyc; } req_t;
  typedef struct { logic [7:0] id; logic [15:0] idx; int rdy; } pend_t;
  typedef struct { logic [383:0] tr; logic [287:0] tri_d; logic tl; logic ml; } beat_t;
  typedef struct {
    logic sv; logic miv; logic [15:0] mi_idx; logic mi_last;
    logic sir; logic mov; logic [15:0] midx; logic tov; logic tl; logic bsy;
  } vec_t;

  req_t  reqs[$];
  pend_t rq[$];
  beat_t beats[$];
  vec_t  vt[7];
  bit    mb_en = 1'b0;
  int    mb_lat = 1;
  int    bad_last_idx = -1;
  int    mb_count[256];

  function automatic logic [383:0] tr_of(logic [7:0] id);
    return {48{id}};
  endfunction

  function automatic logic [287:0] tri_of(logic [7:0] id, logic [15:0] idx);
    return {264'd0, id, idx};
  endfunction

  task automatic chk(string name, logic [383:0] act, logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Records handshakes seen before the edge, then plays the model buffer on the next cycle.
  task automatic tick();
    req_t  r;
    pend_t p;
    beat_t b;
    if (model_out_valid && model_out_ready) begin
      r.id = model_out_model_index; r.idx = model_out_triangle_index; r.cyc = cyc;
      reqs.push_back(r);
      p.id = r.id; p.idx = r.idx; p.rdy = cyc + mb_lat;
      rq.push_back(p);
    end
    if (mb_en && model_in_valid && model_in_ready && rq.size() > 0) rq.delete(0);
    if (tri_out_valid && tri_out_ready) begin
      b.tr = tri_out_transform; b.tri_d = tri_out_triangle;
      b.tl = tri_out_triangle_last; b.ml = tri_out_model_last;
      beats.push_back(b);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (mb_en) begin
      if (rq.size() > 0 && rq[0].rdy <= cyc) begin
        model_in_valid    = 1'b1;
        model_in_triangle = tri_of(rq[0].id, rq[0].idx);
        model_in_last     = (int'(rq[0].idx) == mb_count[rq[0].id] - 1) ||
                            (int'(rq[0].idx) == bad_last_idx);
      end else begin
        model_in_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    scene_in_valid = 1'b0;
    model_in_valid = 1'b0;
    model_in_last  = 1'b0;
    #1;
    @(negedge clk);
    rst = 1'b0;
    reqs.delete(); rq.delete(); beats.delete();
    bad_last_idx = -1;
    #1;
  endtask

  task automatic offer(logic [7:0] id, int cnt, logic ml);
    bit acc = 1'b0;
    scene_in_valid      = 1'b1;
    scene_in_model_id   = id;
    scene_in_tri_count  = 16'(cnt);
    scene_in_transform  = tr_of(id);
    scene_in_model_last = ml;
    mb_count[id] = cnt;
    for (int i = 0; i < 30; i++) begin
      if (scene_in_ready) begin
        acc = 1'b1;
        tick();
        break;
      end
      tick();
    end
    scene_in_valid = 1'b0;
    if (!acc) chk("offer_timeout", 0, 1);
  endtask

  initial begin
    rst = 1'b1;
    scene_in_valid = 1'b0; scene_in_model_id = '0; scene_in_tri_count = '0;
    scene_in_transform = '0; scene_in_model_last = 1'b0;
    model_out_ready = 1'b1; model_in_valid = 1'b0; model_in_triangle = '0;
    model_in_last = 1'b0; tri_out_ready = 1'b1;

    @(negedge clk); #1;
    chk("rst_scene_ready", scene_in_ready, 0);
    chk("rst_mo_valid", model_out_valid, 0);
    chk("rst_to_valid", tri_out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_last", err_last_mismatch, 0);
    chk("rst_err_stray", err_stray, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_scene_ready", scene_in_ready, 1);

    // Single instance id=3 count=4, response one cycle after each request.
    vt[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 16'd0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{1'b0, 1'b1, 16'd0, 1'b0, 1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b0, 1'b1, 16'd1, 1'b0, 1'b1, 1'b1, 16'd2, 1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 16'd2, 1'b0, 1'b1, 1'b1, 16'd3, 1'b1, 1'b0, 1'b1};
    vt[5] = '{1'b0, 1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    scene_in_model_id = 8'd3; scene_in_tri_count = 16'd4;
    scene_in_transform = tr_of(8'd3); scene_in_model_last = 1'b1;
    for (int i = 0; i < 7; i++) begin
      scene_in_valid    = vt[i].sv;
      model_in_valid    = vt[i].miv;
      model_in_triangle = tri_of(8'd3, vt[i].mi_idx);
      model_in_last     = vt[i].mi_last;
      #1;
      chk($sformatf("t1_sir_%0d", i), scene_in_ready, vt[i].sir);
      chk($sformatf("t1_mov_%0d", i), model_out_valid, vt[i].mov);
      chk($sformatf("t1_busy_%0d", i), busy, vt[i].bsy);
      chk($sformatf("t1_tov_%0d", i), tri_out_valid, vt[i].tov);
      if (vt[i].mov) begin
        chk($sformatf("t1_mid_%0d", i), model_out_model_index, 3);
        chk($sformatf("t1_midx_%0d", i), model_out_triangle_index, vt[i].midx);
      end
      if (vt[i].tov) begin
        chk($sformatf("t1_tl_%0d", i), tri_out_triangle_last, vt[i].tl);
        chk($sformatf("t1_ml_%0d", i), tri_out_model_last, 1);
        chk($sformatf("t1_tr_%0d", i), tri_out_transform, tr_of(8'd3));
        chk($sformatf("t1_tri_%0d", i), tri_out_triangle, tri_of(8'd3, vt[i].mi_idx));
      end
      @(negedge clk); #1;
    end
    scene_in_valid = 1'b0; model_in_valid = 1'b0;
    chk("t1_err_last", err_last_mismatch, 0);

    // Two back-to-back instances, model latency 2.
    do_reset();
    mb_en = 1'b1; mb_lat = 2;
    offer(8'd1, 2, 1'b0);
    offer(8'd2, 3, 1'b1);
    run(20);
    chk("t2_nreq", reqs.size(), 5);
    chk("t2_nbeat", beats.size(), 5);
    if (reqs.size() == 5) begin
      chk("t2_r0", {reqs[0].id, reqs[0].idx}, {8'd1, 16'd0});
      chk("t2_r1", {reqs[1].id, reqs[1].idx}, {8'd1, 16'd1});
      chk("t2_r2", {reqs[2].id, reqs[2].idx}, {8'd2, 16'd0});
      chk("t2_r4", {reqs[4].id, reqs[4].idx}, {8'd2, 16'd2});
      chk("t2_nobubble", reqs[2].cyc - reqs[1].cyc, 1);
    end
    if (beats.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        logic [7:0]  eid;
        logic [15:0] eidx;
        eid  = (i < 2) ? 8'd1 : 8'd2;
        eidx = (i < 2) ? 16'(i) : 16'(i - 2);
        chk($sformatf("t2_tr_%0d", i), beats[i].tr, tr_of(eid));
        chk($sformatf("t2_tri_%0d", i), beats[i].tri_d, tri_of(eid, eidx));
        chk($sformatf("t2_tl_%0d", i), beats[i].tl, (i == 1 || i == 4));
        chk($sformatf("t2_ml_%0d", i), beats[i].ml, (i >= 2));
      end
    end
    chk("t2_err_last", err_last_mismatch, 0);
    chk("t2_busy", busy, 0);

    // Credit limit: no responses, then a single response frees one credit.
    do_reset();
    mb_en = 1'b0;
    offer(8'd5, 8, 1'b0);
    run(8);
    chk("t3_nreq4", reqs.size(), 4);
    chk("t3_mov_stall", model_out_valid, 0);
    model_in_valid = 1'b1; model_in_triangle = tri_of(8'd5, 16'd0); model_in_last = 1'b0;
    #1;
    chk("t3_tov", tri_out_valid, 1);
    chk("t3_mir", model_in_ready, 1);
    tick();
    model_in_valid = 1'b0;
    #1;
    chk("t3_mov_again", model_out_valid, 1);
    tick();
    chk("t3_nreq5", reqs.size(), 5);
    chk("t3_mov_stall2", model_out_valid, 0);

    // Context FIFO full with downstream stalled.
    do_reset();
    mb_en = 1'b1; mb_lat = 1; tri_out_ready = 1'b0;
    offer(8'd1, 1, 1'b0);
    chk("t4_sir_2nd", scene_in_ready, 1);
    offer(8'd2, 1, 1'b0);
    scene_in_valid = 1'b1; scene_in_model_id = 8'd3; scene_in_tri_count = 16'd1;
    scene_in_transform = tr_of(8'd3); mb_count[3] = 1;
    #1;
    chk("t4_sir_full", scene_in_ready, 0);
    run(4);
    chk("t4_sir_held", scene_in_ready, 0);
    chk("t4_tov_held", tri_out_valid, 1);
    chk("t4_tr_held", tri_out_transform, tr_of(8'd1));
    tri_out_ready = 1'b1;
    #1;
    chk("t4_sir_retire", scene_in_ready, 0);
    tick();
    chk("t4_sir_after", scene_in_ready, 1);
    tick();
    scene_in_valid = 1'b0;
    run(15);
    chk("t4_nbeat", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("t4_b0", beats[0].tr, tr_of(8'd1));
      chk("t4_b1", beats[1].tr, tr_of(8'd2));
      chk("t4_b2", beats[2].tr, tr_of(8'd3));
    end

    // Zero-count instance between two single-triangle instances.
    do_reset();
    mb_en = 1'b1; mb_lat = 1;
    offer(8'd1, 1, 1'b0);
    chk("t5_sir_zero", scene_in_ready, 1);
    offer(8'd9, 0, 1'b1);
    offer(8'd2, 1, 1'b0);
    run(15);
    chk("t5_nbeat", beats.size(), 2);
    chk("t5_nreq", reqs.size(), 2);
    if (reqs.size() == 2) begin
      chk("t5_r0", reqs[0].id, 1);
      chk("t5_r1", reqs[1].id, 2);
    end
    if (beats.size() == 2) begin
      chk("t5_b0", beats[0].tr, tr_of(8'd1));
      chk("t5_b1", beats[1].tr, tr_of(8'd2));
    end
    chk("t5_busy", busy, 0);

    // Early last from the model buffer, stray response, then a mid-stream reset.
    do_reset();
    mb_en = 1'b1; mb_lat = 1; bad_last_idx = 1;
    offer(8'd4, 3, 1'b1);
    run(15);
    chk("t6_nbeat", beats.size(), 3);
    if (beats.size() == 3) begin
      chk("t6_tl0", beats[0].tl, 0);
      chk("t6_tl1", beats[1].tl, 0);
      chk("t6_tl2", beats[2].tl, 1);
    end
    chk("t6_err_last", err_last_mismatch, 1);
    run(3);
    chk("t6_err_sticky", err_last_mismatch, 1);
    chk("t6_no_stray", err_stray, 0);
    mb_en = 1'b0;
    model_in_valid = 1'b1; model_in_triangle = tri_of(8'd7, 16'd7); model_in_last = 1'b0;
    #1;
    chk("t6_stray_ready", model_in_ready, 1);
    chk("t6_stray_tov", tri_out_valid, 0);
    tick();
    model_in_valid = 1'b0;
    chk("t6_err_stray", err_stray, 1);
    bad_last_idx = -1; mb_en = 1'b1;
    offer(8'd6, 8, 1'b1);
    run(3);
    chk("t6_busy_mid", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_arst_sir", scene_in_ready, 0);
    chk("t6_arst_mov", model_out_valid, 0);
    chk("t6_arst_tov", tri_out_valid, 0);
    chk("t6_arst_busy", busy, 0);
    chk("t6_arst_err_last", err_last_mismatch, 0);
    chk("t6_arst_err_stray", err_stray, 0);
    @(negedge clk);
    rst = 1'b0; mb_en = 1'b0; model_in_valid = 1'b0;
    reqs.delete(); rq.delete(); beats.delete();
    #1;
    chk("t6_rel_sir", scene_in_ready, 1);
    run(3);
    chk("t6_rel_mov", model_out_valid, 0);
    chk("t6_rel_nreq", reqs.size(), 0);
    chk("t6_rel_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scene_reader_pipelined.md
Name: scene_reader_pipelined

Overview:
Successor to the single-instance scene reader. It accepts model instances from the scene buffer into a small context FIFO. For each instance it issues one model-buffer read per triangle, using a counted loop bounded by the instance's triangle count. It pairs each returned triangle with its instance transform. Requests for the next instance overlap the drain of the current one, limited by an outstanding-read credit counter. Last flags are generated internally; the model buffer's last flag is only checked against them.

Parameters:
MODEL_ID_W, 8, width of model index
TRI_IDX_W, 16, width of triangle index/count
TRANSFORM_W, 384, width of packed transform
TRIANGLE_W, 288, width of packed triangle
CTX_DEPTH, 2, instance context FIFO depth (power of two, >=2)
MAX_OUTSTANDING, 4, max issued-but-unreturned reads (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
scene_in_valid  in  1  instance offered
scene_in_ready  out  1  instance accepted when valid&&ready
scene_in_model_id  in  MODEL_ID_W  model index
scene_in_tri_count  in  TRI_IDX_W  triangles in model (0 allowed)
scene_in_transform  in  TRANSFORM_W  instance transform
scene_in_model_last  in  1  last instance of scene
model_out_valid  out  1  read request valid
model_out_ready  in  1  model buffer accepts request
model_out_model_index  out  MODEL_ID_W  requested model
model_out_triangle_index  out  TRI_IDX_W  requested triangle
model_in_valid  in  1  triangle response valid
model_in_ready  out  1  response accepted
model_in_triangle  in  TRIANGLE_W  triangle data
model_in_last  in  1  model buffer's last-triangle flag
tri_out_valid  out  1  paired triangle valid
tri_out_ready  in  1  downstream accepts
tri_out_transform  out  TRANSFORM_W  transform of owning instance
tri_out_triangle  out  TRIANGLE_W  triangle data
tri_out_triangle_last  out  1  last triangle of this instance
tri_out_model_last  out  1  owning instance's model_last, valid on every beat
busy  out  1  any context held or read outstanding
err_last_mismatch  out  1  sticky: model_in_last != internal last
err_stray  out  1  sticky: response with zero outstanding

Behaviour:
- Reset (async, rst=1): FIFO pointers and occupancy = 0; issue index = 0; outstanding = 0; response index = 0.
- Reset output values: scene_in_ready=0 while rst is high, 1 after release; model_out_valid=0; tri_out_valid=0; busy=0; both error flags = 0.
- A reset mid-operation discards all contexts and all in-flight reads.
- Scene accept:
  - scene_in_ready = !ctx_full.
  - tri_count==0: the instance is consumed and not written to the FIFO. No request and no output are produced, and its model_last is lost.
  - tri_count>0: the instance is written at wr_ptr and becomes visible to the issuer in the next cycle.
- Issuer FSM:
  - ISSUE_IDLE: move to ISSUE_RUN when the issue pointer has a context not yet issued.
  - ISSUE_RUN: model_out_valid = (outstanding < MAX_OUTSTANDING). model_out_model_index comes from the issue context; model_out_triangle_index = issue index.
  - On each request handshake: issue index +1. At count-1, the index returns to 0 and the issue pointer advances. If the next context is already present, the FSM stays in ISSUE_RUN with no bubble; otherwise it goes to ISSUE_IDLE.
  - Request index and model index are stable while valid && !ready.
- Response path:
  - Combinational pass-through: tri_out_valid = model_in_valid && outstanding>0; model_in_ready = tri_out_ready || outstanding==0.
  - Transform and model_last come from the context at rd_ptr.
  - tri_out_triangle_last = (response index == count-1).
  - On an output handshake: response index +1. On the last beat, the response index returns to 0, rd_ptr advances and the context is freed.
  - A response arriving with outstanding==0 is accepted and dropped, and err_stray is set.
  - On every output handshake, if model_in_last != tri_out_triangle_last, err_last_mismatch is set. Data is forwarded regardless.
- Counters:
  - outstanding: +1 on a request handshake, -1 on a response accept with outstanding>0, unchanged when both happen in the same cycle. It never exceeds MAX_OUTSTANDING.
  - FIFO occupancy: an accept and a retire in the same cycle leave occupancy unchanged. A full FIFO with a same-cycle retire still deasserts ready, because ready is a registered-free function of the current occupancy.
- Latency: scene handshake in cycle N -> first model_out_valid in cycle N+1 (if credit is available). Response to tri_out is 0 cycles.
- busy = occupancy!=0 || outstanding!=0.

Test Plan:
1. Single instance, id=3, count=4, all readies high -> requests (3,0),(3,1),(3,2),(3,3) in cycles N+1..N+4. Four tri_out beats with the instance transform; triangle_last only on the 4th; model_last is copied on all beats.
2. Two back-to-back instances (id=1 count=2, id=2 count=3), model buffer latency 2 -> request (2,0) follows (1,1) with no bubble. Output order is 1,1,2,2,2, and transforms switch exactly at the boundary.
3. MAX_OUTSTANDING=4, model_in_valid held low -> exactly 4 requests issued, then model_out_valid=0. After one response is accepted, one more request is issued.
4. CTX_DEPTH=2, tri_out_ready=0, three instances offered -> the first two are accepted and scene_in_ready drops. The third is accepted only after the first instance's last beat retires.
5. tri_count=0 instance between two count=1 instances -> accepted immediately, and no request or output is produced for it. Total outputs = 2.
6. Model buffer asserts last on beat 1 of a count=3 instance -> err_last_mismatch=1 and stays 1; all 3 beats are still output. Pulse rst mid-stream -> all outputs and flags return to their reset values asynchronously.
